mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Memory-stage consumer of the Execute→Memory pipeline register outputs (ALUResultM, WriteDataM, MemWriteM, ResultSrcM, sizeSrcM).
Turns each load or store into a single req/ack transaction on a variable-latency data memory port. It stalls the pipeline until the access completes and returns size-extracted, sign- or zero-extended load data as ReadDataM.
It also flags misaligned accesses and bus timeouts.

Parameters:
DATA_WIDTH, 32, data/address width (only 32 supported)
TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack before abort (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ALUResultM  in  32  byte address
WriteDataM  in  32  store data (low bits significant)
MemWriteM  in  1  store request
ResultSrcM  in  2  2'b01 = load; other values = not a load
sizeSrcM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
ReadDataM  out  32  extended load result
StallM  out  1  hold IF..M pipeline registers
MisalignM  out  1  current M-stage access is misaligned (combinational)
BusErrM  out  1  sticky timeout flag
mem_req  out  1  request valid
mem_we  out  1  write strobe
mem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_ack  in  1  transaction complete; mem_rdata valid same cycle
mem_rdata  in  32  read word

Behaviour:
- access = MemWriteM | (ResultSrcM==2'b01). Both set simultaneously → treated as store.
- Misaligned condition: H/HU with addr[0]=1, or W with addr[1:0]≠0. Unknown sizeSrc codes are treated as W.
- Misaligned access: MisalignM=1, no request, no stall, ReadDataM unchanged.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: aligned access → StallM=1 combinationally; latch addr/we/wdata/be/size/addr[1:0] into request registers; go to BUSY.
  - BUSY: mem_req=1 and StallM=1; request fields stable until ack. On mem_ack: load → ReadDataM <= extended data; go to DONE. Timeout counter increments each BUSY cycle without ack; reaching TIMEOUT_CYCLES → BusErrM<=1, ReadDataM<=0, go to DONE.
  - DONE: StallM=0 for exactly one cycle so the pipeline advances; inputs are ignored; go to IDLE.
- mem_ack outside BUSY is ignored.
- Latency: with ack in the first BUSY cycle, stall is 2 cycles (IDLE + BUSY), and ReadDataM is valid in the DONE cycle. Each extra wait cycle adds one stall cycle.
- Store lanes:
  - SB: wdata={4{WriteDataM[7:0]}}, be=4'b0001<<addr[1:0]
  - SH: wdata={2{WriteDataM[15:0]}}, be=4'b0011<<{addr[1],1'b0}
  - SW: wdata=WriteDataM, be=4'b1111
- Loads: mem_we=0, be=4'b1111. Selected lane = mem_rdata>>(8*addr[1:0]). B/H sign-extend; BU/HU zero-extend; W passes through.
- ReadDataM holds its last load value across stores and idle cycles.
- Reset (rst=0, async): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, ReadDataM=0, BusErrM=0, timeout counter=0.
  - StallM=0 while in reset.
  - Reset during BUSY drops mem_req immediately; the aborted transaction is not replayed.

Test Plan:
- LW addr 0x100, ack on 1st BUSY cycle, rdata 0xDEADBEEF → mem_req 1 cycle, be=1111, StallM high 2 cycles, ReadDataM=0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80FF1234 → ReadDataM=0xFFFFFF80. Same with LBU → 0x00000080. LH 0x102 → 0xFFFF80FF.
- SB addr 0x201, WriteDataM 0x000000AB → mem_we=1, mem_addr=0x200, be=0010, wdata=0xABABABAB. SH 0x202 data 0x1234 → be=1100, wdata=0x12341234.
- LW addr 0x102 → MisalignM=1, mem_req never asserted, StallM=0, ReadDataM unchanged.
- LW with mem_ack held low, TIMEOUT_CYCLES=4 → exactly 4 BUSY cycles, then BusErrM=1, ReadDataM=0, one DONE cycle with StallM=0. BusErrM stays 1 until reset.
- Assert rst low during BUSY with 3 wait cycles → mem_req and StallM drop immediately. After release: IDLE, all outputs 0, stray mem_ack ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one req/ack transaction per aligned access,
// stalls the pipeline until completion, and returns size-extended load data.
module mem_access_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic                  MemWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic [2:0]            sizeSrcM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  MisalignM,
    output logic                  BusErrM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          stall_c, latch_c, capture_c, timeout_c;

    logic [1:0]    req_size;
    logic          req_uns;
    logic [1:0]    req_off;

    logic          access, size_b, size_h, misal;
    logic [DW-1:0] st_wdata;
    logic [3:0]    st_be;
    logic [DW-1:0] lane, ld_data;

    // Access decode; a simultaneous load+store request behaves as a store.
    assign access = MemWriteM | (ResultSrcM == 2'b01);
    assign size_b = (sizeSrcM[1:0] == 2'b00);
    assign size_h = (sizeSrcM[1:0] == 2'b01);
    assign misal  = (size_h & ALUResultM[0]) |
                    (~size_b & ~size_h & (ALUResultM[1:0] != 2'b00));

    assign MisalignM = access & misal;
    assign StallM    = rst & stall_c;
    assign mem_req   = (state == BUSY);

    // Store lane replication and byte enables
    always_comb begin
        st_wdata = '0;
        st_be    = 4'b1111;
        if (MemWriteM) begin
            if (size_b) begin
                st_wdata = {4{WriteDataM[7:0]}};
                st_be    = 4'b0001 << ALUResultM[1:0];
            end else if (size_h) begin
                st_wdata = {2{WriteDataM[15:0]}};
                st_be    = 4'b0011 << {ALUResultM[1], 1'b0};
            end else begin
                st_wdata = WriteDataM;
            end
        end
    end

    // Load lane select and extension
    assign lane = mem_rdata >> {req_off, 3'b000};
    always_comb begin
        case (req_size)
            2'b00:   ld_data = {{24{~req_uns & lane[7]}}, lane[7:0]};
            2'b01:   ld_data = {{16{~req_uns & lane[15]}}, lane[15:0]};
            default: ld_data = lane;
        endcase
    end

    // Next-state and control
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        stall_c   = 1'b0;
        latch_c   = 1'b0;
        capture_c = 1'b0;
        timeout_c = 1'b0;
        case (state)
            IDLE: begin
                if (access && !misal) begin
                    stall_c = 1'b1;
                    latch_c = 1'b1;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    capture_c = ~mem_we;
                    state_n   = DONE;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_c = 1'b1;
                    state_n   = DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            req_size  <= '0;
            req_uns   <= 1'b0;
            req_off   <= '0;
            ReadDataM <= '0;
            BusErrM   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (latch_c) begin
                mem_we    <= MemWriteM;
                mem_addr  <= {ALUResultM[DW-1:2], 2'b00};
                mem_wdata <= st_wdata;
                mem_be    <= st_be;
                req_size  <= sizeSrcM[1:0];
                req_uns   <= sizeSrcM[2];
                req_off   <= ALUResultM[1:0];
            end
            if (capture_c) ReadDataM <= ld_data;
            // A timed-out access returns zero and leaves a sticky error until reset.
            if (timeout_c) begin
                ReadDataM <= '0;
                BusErrM   <= 1'b1;
            end
        end
    end

endmodule
